// File: rtl/sp_ram_bist.sv
// sp_ram_bist: on-chip LFSR write/read-verify self-test engine for the single-port sp_ram macro.
// Optional build macro SP_RAM_BIST_INV_PASS_EN adds a second pass that writes and checks ~LFSR data.
module sp_ram_bist #(
    parameter int          DATA_W       = 32,
    parameter int          ADDR_W       = 10,
    parameter int          DEPTH        = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SEED         = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0]       LFSR_TAPS  = 32'h8020_0003;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY - 1);
    localparam int                REP        = (DATA_W + 31) / 32;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic [2:0]        drain_q, drain_d;
`ifdef SP_RAM_BIST_INV_PASS_EN
    logic              inv_q, inv_d;
`endif

    // Read-compare pipeline: stage READ_LATENCY-1 lines up with mem_q.
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_exp_q  [READ_LATENCY];

    logic [REP*32-1:0] lfsr_wide;
    logic [DATA_W-1:0] pat_word;
    logic              cmp_miss;

    assign lfsr_wide = {REP{lfsr_q}};

    // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
    always_comb begin
        pat_word = lfsr_wide[DATA_W-1:0];
`ifdef SP_RAM_BIST_INV_PASS_EN
        if (inv_q) pat_word = ~lfsr_wide[DATA_W-1:0];
`endif
    end

    // X on mem_q must count as a miss in simulation, hence case-inequality.
    assign cmp_miss = pipe_vld_q[READ_LATENCY-1] && (mem_q !== pipe_exp_q[READ_LATENCY-1]);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        addr_d  = addr_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;
        drain_d = drain_q;
`ifdef SP_RAM_BIST_INV_PASS_EN
        inv_d   = inv_q;
`endif

        if (cmp_miss) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = pipe_addr_q[READ_LATENCY-1];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WRITE;
                    lfsr_d  = SEED;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
`ifdef SP_RAM_BIST_INV_PASS_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            ST_WRITE: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_READ;
                    lfsr_d  = SEED;
                    addr_d  = '0;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_READ: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
`ifdef SP_RAM_BIST_INV_PASS_EN
                    if (!inv_q) begin
                        state_d = ST_WRITE;
                        inv_d   = 1'b1;
                        lfsr_d  = SEED;
                        addr_d  = '0;
                        we_d    = 1'b1;
                    end else
`endif
                    begin
                        // err_d already holds the compare retiring on this same edge.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'd0);
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            drain_q <= '0;
`ifdef SP_RAM_BIST_INV_PASS_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            drain_q <= drain_d;
`ifdef SP_RAM_BIST_INV_PASS_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= (state_q == ST_READ);
            for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
        end
    end

    // NOTE: the address/data pipe is deliberately not reset; its valid bit gates every use.
    always_ff @(posedge clk) begin
        pipe_addr_q[0] <= addr_q;
        pipe_exp_q[0]  <= pat_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_addr_q[i] <= pipe_addr_q[i-1];
            pipe_exp_q[i]  <= pipe_exp_q[i-1];
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign mem_addr       = addr_q;
    assign mem_we         = we_q;
    assign mem_data       = we_q ? pat_word : '0;

endmodule
